// File: rtl/cluster_tx_scheduler_pkg.sv
// Package cluster_pkg: shared cluster geometry, the cluster record, the
// scheduler FSM state type and small helpers (slot validity, popcount).
// Imported by the scheduler top and its FIFO.
package cluster_pkg;

    localparam int MXCLUSTERS = 8;   // cluster slots per BX
    localparam int MXCLSTBITS = 14;  // {cnt, adr}
    localparam int MXADRBITS  = 11;
    localparam int MXCNTBITS  = 3;
    localparam int PCW        = $clog2(MXCLUSTERS + 1);  // popcount width

    // Addresses at or above this value mark an empty slot.
    localparam logic [MXADRBITS-1:0] CLUSTER_INVALID_MIN = MXADRBITS'(1536);

    typedef struct packed {
        logic [MXCNTBITS-1:0] cnt;
        logic [MXADRBITS-1:0] adr;
    } cluster_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } sched_state_t;

    function automatic logic cluster_valid(input cluster_t c);
        return c.adr < CLUSTER_INVALID_MIN;
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [MXCLUSTERS-1:0] m);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < MXCLUSTERS; i++) n += PCW'(m[i]);
        return n;
    endfunction

endpackage

// File: rtl/cluster_tx_scheduler_if.sv
// Interface cluster_tx_scheduler_if: cluster snapshot input and the
// valid/ready link output of the scheduler.
//   clusters_in, bx_strobe        : packer side (slot i at [i*14+13:i*14])
//   out_cluster/out_tag/out_valid : link side, out_ready from serializer
//   out_parity                    : only with CLUSTER_SCHED_PARITY_EN
// modport master = the scheduler, modport slave = its environment.
interface cluster_tx_scheduler_if #(
    parameter int MXCLUSTERS = 8,
    parameter int MXCLSTBITS = 14,
    parameter int TAGBITS    = 3
);
    logic [MXCLUSTERS*MXCLSTBITS-1:0] clusters_in;
    logic                             bx_strobe;
    logic [MXCLSTBITS-1:0]            out_cluster;
    logic [TAGBITS-1:0]               out_tag;
    logic                             out_valid;
    logic                             out_ready;
`ifdef CLUSTER_SCHED_PARITY_EN
    logic                             out_parity;
`endif

    modport master (
        input  clusters_in, bx_strobe, out_ready,
`ifdef CLUSTER_SCHED_PARITY_EN
        output out_parity,
`endif
        output out_cluster, out_tag, out_valid
    );

    modport slave (
        output clusters_in, bx_strobe, out_ready,
`ifdef CLUSTER_SCHED_PARITY_EN
        input  out_parity,
`endif
        input  out_cluster, out_tag, out_valid
    );
endinterface

// File: rtl/cluster_tx_scheduler_fifo.sv
// cluster_sched_fifo: 2-write / 1-read show-ahead FIFO with a registered
// output word. Total occupancy (memory + output register) never exceeds
// DEPTH because writers are limited by 'free'.
//   clk, rst_n     : clock, async active-low reset
//   wr_n, wr_d0/1  : push 0, 1 or 2 words this cycle (d0 first)
//   free           : DEPTH - occupancy, before any pop this cycle
//   rd_valid/ready : head handshake, rd_data held while not accepted
module cluster_sched_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               wr_n,
    input  logic [WIDTH-1:0]         wr_d0,
    input  logic [WIDTH-1:0]         wr_d1,
    output logic [$clog2(DEPTH):0]   free,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr1, rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             pop, load;

    assign pop     = rd_valid && rd_ready;
    // Refill the output register whenever it is empty or being consumed.
    assign load    = (mem_cnt != '0) && (!rd_valid || pop);
    assign wr_ptr1 = wr_ptr + 1'b1;
    assign free    = CW'(DEPTH) - mem_cnt - CW'(rd_valid);

    always_ff @(posedge clk) begin
        if (wr_n != 2'd0) mem[wr_ptr]  <= wr_d0;
        if (wr_n == 2'd2) mem[wr_ptr1] <= wr_d1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(wr_n);
            mem_cnt <= mem_cnt + CW'(wr_n) - CW'(load);
            if (load) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cluster_tx_scheduler.sv
// cluster_tx_scheduler: captures the 8 cluster slots on each bx_strobe,
// drops empty slots, pushes valid clusters two per cycle into a FIFO and
// hands them one at a time to the trigger link, each tagged with a BX tag.
// BXs arriving while a previous one is still draining are rejected and
// their valid clusters counted in drop_cnt.
//   clock4x, global_reset_n : 160 MHz clock, async active-low reset
//   link (master)           : clusters_in/bx_strobe in, out_* handshake
//   busy                    : holding register occupied (DRAIN)
//   drop_cnt, overflow      : saturating drop count, sticky drop flag
// Optional macro CLUSTER_SCHED_PARITY_EN adds link.out_parity
// (XOR of {out_tag, out_cluster}), stored in the FIFO with the word.
module cluster_tx_scheduler
    import cluster_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int TAGBITS    = 3,
    parameter int DROPBITS   = 16
) (
    input  logic                    clock4x,
    input  logic                    global_reset_n,
    cluster_tx_scheduler_if.master  link,
    output logic                    busy,
    output logic [DROPBITS-1:0]     drop_cnt,
    output logic                    overflow
);
    localparam int SW = $clog2(MXCLUSTERS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef CLUSTER_SCHED_PARITY_EN
    localparam int FW = MXCLSTBITS + TAGBITS + 1;
`else
    localparam int FW = MXCLSTBITS + TAGBITS;
`endif

    sched_state_t                         state, state_nxt;
    cluster_t     [MXCLUSTERS-1:0]        slot_in, hold_slot;
    logic         [MXCLUSTERS-1:0]        slot_vld, hold_mask, mask_nxt;
    logic         [TAGBITS-1:0]           tag_cnt, hold_tag;
    logic         [SW-1:0]                sel_a, sel_b;
    logic                                 has_a, has_b;
    logic         [1:0]                   n_push;
    logic         [CW-1:0]                free;
    logic         [FW-1:0]                word_a, word_b, rd_word;
    logic                                 accept, reject;
    logic         [PCW-1:0]               drop_pc;
    logic         [DROPBITS+PCW-1:0]      drop_sum;
    logic         [DROPBITS-1:0]          drop_sat;

    assign slot_in = link.clusters_in;

    for (genvar i = 0; i < MXCLUSTERS; i++) begin : g_vld
        assign slot_vld[i] = cluster_valid(slot_in[i]);
    end

    // Lowest pending slot -> A, next lowest -> B.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        has_a = 1'b0;
        has_b = 1'b0;
        for (int i = MXCLUSTERS - 1; i >= 0; i--) begin
            if (hold_mask[i]) begin
                sel_b = sel_a;
                has_b = has_a;
                sel_a = i[SW-1:0];
                has_a = 1'b1;
            end
        end
    end

    // Push as many of A, B as the FIFO has room for; zero room = stall.
    always_comb begin
        n_push   = 2'd0;
        mask_nxt = hold_mask;
        if (state == S_DRAIN) begin
            if (has_a && free != '0)     n_push = 2'd1;
            if (has_b && free >= CW'(2)) n_push = 2'd2;
        end
        if (n_push != 2'd0) mask_nxt[sel_a] = 1'b0;
        if (n_push == 2'd2) mask_nxt[sel_b] = 1'b0;
    end

    assign accept = link.bx_strobe && (state == S_IDLE);
    // Covers the return-to-IDLE cycle too: the state register is still DRAIN.
    assign reject = link.bx_strobe && (state == S_DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && slot_vld != '0) state_nxt = S_DRAIN;
            S_DRAIN: if (mask_nxt == '0)           state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) state <= S_IDLE;
        else                 state <= state_nxt;
    end

    assign drop_pc  = popcount(slot_vld);
    assign drop_sum = {{PCW{1'b0}}, drop_cnt} + (DROPBITS+PCW)'(drop_pc);
    assign drop_sat = (drop_sum > {{PCW{1'b0}}, {DROPBITS{1'b1}}}) ? '1
                                                                   : drop_sum[DROPBITS-1:0];

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            hold_slot <= '0;
            hold_mask <= '0;
            hold_tag  <= '0;
            tag_cnt   <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (link.bx_strobe) tag_cnt <= tag_cnt + 1'b1;
            if (accept) begin
                hold_slot <= slot_in;
                hold_mask <= slot_vld;
                hold_tag  <= tag_cnt;
            end else begin
                hold_mask <= mask_nxt;
            end
            if (reject) begin
                drop_cnt <= drop_sat;
                if (drop_pc != '0) overflow <= 1'b1;
            end
        end
    end

`ifdef CLUSTER_SCHED_PARITY_EN
    assign word_a = {^{hold_tag, hold_slot[sel_a]}, hold_tag, hold_slot[sel_a]};
    assign word_b = {^{hold_tag, hold_slot[sel_b]}, hold_tag, hold_slot[sel_b]};
    assign link.out_parity = rd_word[FW-1];
`else
    assign word_a = {hold_tag, hold_slot[sel_a]};
    assign word_b = {hold_tag, hold_slot[sel_b]};
`endif

    cluster_sched_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clock4x),
        .rst_n    (global_reset_n),
        .wr_n     (n_push),
        .wr_d0    (word_a),
        .wr_d1    (word_b),
        .free     (free),
        .rd_valid (link.out_valid),
        .rd_ready (link.out_ready),
        .rd_data  (rd_word)
    );

    assign link.out_cluster = rd_word[MXCLSTBITS-1:0];
    assign link.out_tag     = rd_word[MXCLSTBITS +: TAGBITS];
    assign busy             = (state == S_DRAIN);
endmodule
